biquad_channel_scheduler: RTL and testbench
===========================================

BIQUAD_CHANNEL_SCHEDULER -- requirements
Module: biquad_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of multiplexed EEG channels (2..16).
REQ-002 SHALL have parameter CORE_TIMEOUT, default 15, maximum cycles to wait for core_done.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1; low clears all channel state and returns to IDLE.
REQ-006 SHALL have ports sample_valid/sample_ready, input/output, 1/1; valid/ready sample handshake.
REQ-007 SHALL have port sample_ch, input, CH_W = $clog2(NUM_CH), sample channel index.
REQ-008 SHALL have port sample_in, input, 32 signed, raw sample.
REQ-009 SHALL have ports core_start, output, 1, and core_x0/core_x1/core_x2/core_y1/core_y2, output, 32 signed each; context issued to the shared biquad core.
REQ-010 SHALL have ports core_done, input, 1, and core_y, input, 32 signed; core result.
REQ-011 SHALL have ports out_valid, output, 1, out_ch, output, CH_W, and out_data, output, 32 signed; filtered result, no backpressure.
REQ-012 SHALL have ports err_timeout, output, 1, sticky, and err_ch, output, 1, single-cycle pulse.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> ISSUE -> WAIT -> WRITE -> IDLE, plus ERR.
REQ-014 SHALL drive sample_ready=1 only in IDLE; acceptance is sample_valid & sample_ready.
REQ-015 SHALL, on acceptance with sample_ch >= NUM_CH, drop the sample, pulse err_ch next cycle, and stay in IDLE.
REQ-016 SHALL in LOAD read channel context {x1,x2,y1,y2} and latch the accepted sample as x0.
REQ-017 SHALL in ISSUE assert core_start for exactly one cycle with core_x0..core_y2 valid; core_x*/core_y* hold value until the next ISSUE.
REQ-018 SHALL in WAIT sample core_done only; a core_done outside WAIT is ignored.
REQ-019 SHALL on core_done in cycle T enter WRITE at T+1: out_valid=1 for one cycle, out_ch = the channel, out_data = core_y captured at T.
REQ-020 SHALL in WRITE update the context: x2<=x1, x1<=x0, y2<=y1, y1<=core_y.
REQ-021 SHALL, if core_done is absent for CORE_TIMEOUT cycles in WAIT, enter ERR for one cycle: set err_timeout, no out_valid, context unchanged, then IDLE.
REQ-022 SHALL give minimum latency of 4 cycles from acceptance to out_valid when core_done arrives the first WAIT cycle, i.e. one sample per 5 cycles.
REQ-023 SHALL, when enable is low, force IDLE, sample_ready=0, core_start=0, out_valid=0, zero all contexts and clear err_timeout; an in-flight sample is discarded.
REQ-024 SHALL keep channels independent: processing channel k never modifies context j != k.

Reset
REQ-025 SHALL on rst asynchronously force IDLE, zero all contexts, and drive sample_ready=0 during rst, then 1 from the first cycle after release.
REQ-026 SHALL on rst drive core_start, out_valid, err_ch, err_timeout to 0, and out_ch, out_data, core_x*, core_y* to 0.
REQ-027 SHALL on rst mid-operation (LOAD..WRITE) drop that sample with no out_valid.

Configuration
REQ-028 SHALL support macro HPF_SETTLE_BLANK_EN: when defined, keep a per-channel 9-bit saturating output counter and force out_data=0 for the first 256 outputs of each channel after reset/enable-low (context still updated); counters clear with contexts.
REQ-029 SHALL, without HPF_SETTLE_BLANK_EN, instantiate no counters and output core_y unmodified.

Structure
REQ-030 SHALL place in shared package biquad_pkg: sample_t (logic signed [31:0]), biquad_ctx_t struct {x1,x2,y1,y2}, sched_state_e enum, SETTLE_LEN=256.
REQ-031 SHALL use sub-module biquad_ctx_regfile: NUM_CH x biquad_ctx_t, one read port, one write port, async clear.

Verification
REQ-032 SHALL check: rst, ch0 sample 1000, core_done with core_y=1000 after 1 WAIT cycle -> out_valid 4 cycles after acceptance, out_data=1000 (0 with HPF_SETTLE_BLANK_EN).
REQ-033 SHALL check: ch3 then ch3 samples 500, 700 -> second ISSUE shows core_x1=500, core_y1=first core_y; ch0 context still zero.
REQ-034 SHALL check: core_done withheld -> after 15 WAIT cycles err_timeout=1, no out_valid, sample_ready=1 next cycle, context unchanged.
REQ-035 SHALL check: NUM_CH=6, sample_ch=7 -> err_ch one-cycle pulse, no core_start.
REQ-036 SHALL check: enable low during WAIT -> no out_valid, err_timeout cleared, next sample on that channel issues core_x1=core_y1=0.
REQ-037 SHALL check (macro on): 257 samples on ch1 -> outputs 1..256 are 0, output 257 equals core_y.

Source files
------------

// File: rtl/biquad_pkg.sv
// biquad_pkg: shared types and constants for the biquad channel scheduler
package biquad_pkg;
  typedef logic signed [31:0] sample_t;
  typedef struct packed {
    sample_t x1;
    sample_t x2;
    sample_t y1;
    sample_t y2;
  } biquad_ctx_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_ERR
  } sched_state_e;
  localparam int SETTLE_LEN = 256;
endpackage

// File: rtl/biquad_ctx_regfile.sv
// biquad_ctx_regfile: per-channel biquad history, one async read port, one write port
module biquad_ctx_regfile
  import biquad_pkg::*;
#(
  parameter int NUM_CH = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [CH_W-1:0] rd_addr,
  output biquad_ctx_t     rd_data,
  input  logic            we,
  input  logic [CH_W-1:0] wr_addr,
  input  biquad_ctx_t     wr_data
);
  biquad_ctx_t mem [NUM_CH];
  assign rd_data = mem[rd_addr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end
endmodule

// File: rtl/biquad_channel_scheduler.sv
// biquad_channel_scheduler: time-multiplexes EEG channels onto one shared biquad core.
// Optional HPF_SETTLE_BLANK_EN zeroes the first SETTLE_LEN outputs of each channel.
module biquad_channel_scheduler
  import biquad_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CORE_TIMEOUT = 15,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            sample_valid,
  output logic            sample_ready,
  input  logic [CH_W-1:0] sample_ch,
  input  sample_t         sample_in,
  output logic            core_start,
  output sample_t         core_x0,
  output sample_t         core_x1,
  output sample_t         core_x2,
  output sample_t         core_y1,
  output sample_t         core_y2,
  input  logic            core_done,
  input  sample_t         core_y,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output sample_t         out_data,
  output logic            err_timeout,
  output logic            err_ch
);
  localparam int TW = $clog2(CORE_TIMEOUT + 1);
  sched_state_e state, next_state;
  logic [CH_W-1:0] ch_q;
  sample_t x0_q, y_q;
  logic [TW-1:0] wait_cnt;
  logic accept, bad_ch, timeout, blank;
  biquad_ctx_t rd_ctx, wr_ctx;
  // rst gates ready combinationally so nothing is accepted while reset is held
  assign sample_ready = state == S_IDLE && enable && !rst;
  assign accept = sample_valid && sample_ready;
  assign bad_ch = {1'b0, sample_ch} >= (CH_W + 1)'(NUM_CH);
  assign timeout = wait_cnt == TW'(CORE_TIMEOUT - 1);
  assign core_start = state == S_ISSUE && enable;
  assign out_valid = state == S_WRITE && enable;
  assign wr_ctx = '{x1: core_x0, x2: core_x1, y1: y_q, y2: core_y1};
  biquad_ctx_regfile #(.NUM_CH(NUM_CH)) u_ctx (
    .clk(clk),
    .rst(rst),
    .clr(!enable),
    .rd_addr(ch_q),
    .rd_data(rd_ctx),
    .we(out_valid),
    .wr_addr(ch_q),
    .wr_data(wr_ctx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = accept && !bad_ch ? S_LOAD : S_IDLE;
      S_LOAD:  next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  next_state = core_done ? S_WRITE : timeout ? S_ERR : S_WAIT;
      default: next_state = S_IDLE;
    endcase
    if (!enable) next_state = S_IDLE;
  end
`ifdef HPF_SETTLE_BLANK_EN
  logic [8:0] settle_cnt [NUM_CH];
  assign blank = settle_cnt[ch_q] < 9'(SETTLE_LEN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !enable) begin
      for (int i = 0; i < NUM_CH; i++) settle_cnt[i] <= '0;
    end else if (state == S_WRITE && settle_cnt[ch_q] != '1) begin
      settle_cnt[ch_q] <= settle_cnt[ch_q] + 9'd1;
    end
  end
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q <= '0;
      x0_q <= '0;
      y_q <= '0;
      wait_cnt <= '0;
      core_x0 <= '0;
      core_x1 <= '0;
      core_x2 <= '0;
      core_y1 <= '0;
      core_y2 <= '0;
      out_ch <= '0;
      out_data <= '0;
      err_timeout <= 1'b0;
      err_ch <= 1'b0;
    end else if (!enable) begin
      wait_cnt <= '0;
      err_timeout <= 1'b0;
      err_ch <= 1'b0;
    end else begin
      err_ch <= accept && bad_ch;
      wait_cnt <= state == S_WAIT ? wait_cnt + 1'b1 : '0;
      if (accept && !bad_ch) begin
        ch_q <= sample_ch;
        x0_q <= sample_in;
      end
      if (state == S_LOAD) begin
        core_x0 <= x0_q;
        core_x1 <= rd_ctx.x1;
        core_x2 <= rd_ctx.x2;
        core_y1 <= rd_ctx.y1;
        core_y2 <= rd_ctx.y2;
      end
      // raw core_y feeds the context; only the visible output is blanked
      if (state == S_WAIT && core_done) begin
        y_q <= core_y;
        out_ch <= ch_q;
        out_data <= blank ? '0 : core_y;
      end
      if (state == S_WAIT && !core_done && timeout) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_biquad_channel_scheduler.sv
// tb_biquad_channel_scheduler: directed checks of the channel scheduler with a hand-driven core
module tb_biquad_channel_scheduler;
`ifdef HPF_SETTLE_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, enable, sample_valid, sample_ready, core_start, core_done, out_valid, err_timeout, err_ch;
  logic [2:0] sample_ch, out_ch;
  logic signed [31:0] sample_in, core_y, out_data, core_x0, core_x1, core_x2, core_y1, core_y2;
  logic v6, rdy6, start6, done6, ov6, et6, ec6;
  logic [2:0] ch6, och6;
  logic signed [31:0] x60, x61, x62, y61, y62, od6;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  biquad_channel_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_ch(sample_ch), .sample_in(sample_in), .core_start(core_start), .core_x0(core_x0),
    .core_x1(core_x1), .core_x2(core_x2), .core_y1(core_y1), .core_y2(core_y2), .core_done(core_done),
    .core_y(core_y), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .err_timeout(err_timeout), .err_ch(err_ch)
  );

  biquad_channel_scheduler #(.NUM_CH(6)) dut6 (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(v6), .sample_ready(rdy6),
    .sample_ch(ch6), .sample_in(sample_in), .core_start(start6), .core_x0(x60),
    .core_x1(x61), .core_x2(x62), .core_y1(y61), .core_y2(y62), .core_done(done6),
    .core_y(core_y), .out_valid(ov6), .out_ch(och6), .out_data(od6),
    .err_timeout(et6), .err_ch(ec6)
  );

  function automatic logic signed [31:0] exp_y(input logic signed [31:0] y);
    return BLANK ? 32'sd0 : y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic to_issue(input logic [2:0] ch, input logic signed [31:0] x);
    sample_valid = 1'b1;
    sample_ch = ch;
    sample_in = x;
    tick;
    sample_valid = 1'b0;
    tick;
  endtask

  task automatic finish_core(input logic signed [31:0] y);
    tick;
    core_done = 1'b1;
    core_y = y;
    tick;
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample_ch = '0; sample_in = '0;
    core_done = 1'b0; core_y = '0; v6 = 1'b0; ch6 = '0; done6 = 1'b0;
    repeat (2) tick;
    tests++;
    if ({sample_ready, rdy6} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b want 00", {sample_ready, rdy6});
    end
    tests++;
    if ({core_start, out_valid, err_timeout, err_ch} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {core_start, out_valid, err_timeout, err_ch});
    end
    tests++;
    if ({out_ch, out_data, core_x0, core_x1, core_x2, core_y1, core_y2} !== '0) begin
      fails++; $display("FAIL reset_data: out_data %0d core_x0 %0d want 0", out_data, core_x0);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (sample_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_rst: got %b want 1", sample_ready);
    end
  endtask

  task automatic test_main;
    int n;
    sample_valid = 1'b1; sample_ch = 3'd0; sample_in = 1000; core_done = 1'b1; core_y = 1000;
    tick;
    sample_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    core_done = 1'b0;
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL latency: got %0d want 4", n);
    end
    tests++;
    if ({out_ch, out_data} !== {3'd0, exp_y(1000)}) begin
      fails++; $display("FAIL main_out: ch %0d data %0d want ch 0 data %0d", out_ch, out_data, exp_y(1000));
    end
    tick;
    tests++;
    if ({out_valid, sample_ready} !== 2'b01) begin
      fails++; $display("FAIL main_idle: valid/ready %b want 01", {out_valid, sample_ready});
    end
  endtask

  task automatic test_context;
    to_issue(3'd3, 500);
    tests++;
    if ({core_start, core_x0, core_x1, core_x2, core_y1, core_y2} !== {1'b1, 32'sd500, 128'd0}) begin
      fails++; $display("FAIL ctx_first: start %b x0 %0d x1 %0d y1 %0d want 1 500 0 0", core_start, core_x0, core_x1, core_y1);
    end
    tick;
    tests++;
    if ({core_start, out_valid} !== 2'b00) begin
      fails++; $display("FAIL start_one_cycle: start/valid %b want 00", {core_start, out_valid});
    end
    core_done = 1'b1; core_y = 123;
    tick;
    core_done = 1'b0;
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd3, exp_y(123)}) begin
      fails++; $display("FAIL ctx_out: valid %b ch %0d data %0d want 1 3 %0d", out_valid, out_ch, out_data, exp_y(123));
    end
    tick;
    to_issue(3'd3, -700);
    tests++;
    if ({core_x0, core_x1, core_x2, core_y1, core_y2} !== {-32'sd700, 32'sd500, 32'sd0, 32'sd123, 32'sd0}) begin
      fails++; $display("FAIL ctx_second: x0 %0d x1 %0d x2 %0d y1 %0d y2 %0d want -700 500 0 123 0", core_x0, core_x1, core_x2, core_y1, core_y2);
    end
    finish_core(456);
    tick;
    to_issue(3'd3, 800);
    tests++;
    if ({core_x0, core_x1, core_x2, core_y1, core_y2} !== {32'sd800, -32'sd700, 32'sd500, 32'sd456, 32'sd123}) begin
      fails++; $display("FAIL ctx_third: x0 %0d x1 %0d x2 %0d y1 %0d y2 %0d want 800 -700 500 456 123", core_x0, core_x1, core_x2, core_y1, core_y2);
    end
    finish_core(1);
    tick;
    to_issue(3'd0, 5);
    tests++;
    if ({core_x0, core_x1, core_x2, core_y1, core_y2} !== {32'sd5, 32'sd1000, 32'sd0, 32'sd1000, 32'sd0}) begin
      fails++; $display("FAIL ctx_independent: x1 %0d x2 %0d y1 %0d y2 %0d want 1000 0 1000 0", core_x1, core_x2, core_y1, core_y2);
    end
    finish_core(2);
    tick;
  endtask

  task automatic test_timeout;
    logic bad;
    bad = 1'b0;
    to_issue(3'd2, 42);
    tick;
    repeat (14) begin
      bad |= out_valid | err_timeout | sample_ready;
      tick;
    end
    tests++;
    if ({bad, err_timeout, sample_ready} !== 3'b000) begin
      fails++; $display("FAIL timeout_early: bad/err/ready %b want 000", {bad, err_timeout, sample_ready});
    end
    tick;
    tests++;
    if ({err_timeout, out_valid, sample_ready} !== 3'b100) begin
      fails++; $display("FAIL timeout_err: err/valid/ready %b want 100", {err_timeout, out_valid, sample_ready});
    end
    tick;
    tests++;
    if ({err_timeout, sample_ready} !== 2'b11) begin
      fails++; $display("FAIL timeout_recover: err/ready %b want 11", {err_timeout, sample_ready});
    end
    to_issue(3'd2, 43);
    tests++;
    if ({core_x0, core_x1, core_x2, core_y1, core_y2} !== {32'sd43, 128'd0}) begin
      fails++; $display("FAIL timeout_ctx: x1 %0d y1 %0d want 0 0", core_x1, core_y1);
    end
    finish_core(9);
    tick;
  endtask

  task automatic test_bad_ch;
    v6 = 1'b1; ch6 = 3'd7;
    tests++;
    if (rdy6 !== 1'b1) begin
      fails++; $display("FAIL badch_ready: got %b want 1", rdy6);
    end
    tick;
    v6 = 1'b0;
    tests++;
    if ({ec6, start6, rdy6} !== 3'b101) begin
      fails++; $display("FAIL badch_pulse: err/start/ready %b want 101", {ec6, start6, rdy6});
    end
    tick;
    tests++;
    if ({ec6, start6, rdy6} !== 3'b001) begin
      fails++; $display("FAIL badch_after: err/start/ready %b want 001", {ec6, start6, rdy6});
    end
    v6 = 1'b1; ch6 = 3'd5;
    tick;
    v6 = 1'b0;
    tests++;
    if ({ec6, rdy6} !== 2'b00) begin
      fails++; $display("FAIL goodch6: err/ready %b want 00", {ec6, rdy6});
    end
  endtask

  task automatic test_enable;
    to_issue(3'd4, 900);
    finish_core(77);
    tick;
    to_issue(3'd4, 300);
    tick;
    enable = 1'b0; core_done = 1'b1; core_y = 55;
    tick;
    tests++;
    if ({out_valid, err_timeout, sample_ready, core_start} !== 4'b0) begin
      fails++; $display("FAIL enable_low: valid/err/ready/start %b want 0000", {out_valid, err_timeout, sample_ready, core_start});
    end
    enable = 1'b1; core_done = 1'b0;
    #1;
    tests++;
    if (sample_ready !== 1'b1) begin
      fails++; $display("FAIL enable_ready: got %b want 1", sample_ready);
    end
    to_issue(3'd4, 400);
    tests++;
    if ({core_x0, core_x1, core_x2, core_y1, core_y2} !== {32'sd400, 128'd0}) begin
      fails++; $display("FAIL enable_ctx: x1 %0d y1 %0d want 0 0", core_x1, core_y1);
    end
    finish_core(3);
    tests++;
    if ({out_valid, out_data} !== {1'b1, exp_y(3)}) begin
      fails++; $display("FAIL enable_out: valid %b data %0d want 1 %0d", out_valid, out_data, exp_y(3));
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic bad;
    bad = 1'b0;
    core_done = 1'b1; core_y = 999;
    repeat (2) begin
      bad |= out_valid | ~sample_ready;
      tick;
    end
    core_done = 1'b0;
    tests++;
    if (bad !== 1'b0) begin
      fails++; $display("FAIL done_in_idle: got %b want 0", bad);
    end
    to_issue(3'd5, 1);
    finish_core(11);
    tick;
    tests++;
    if ({out_valid, sample_ready} !== 2'b01) begin
      fails++; $display("FAIL b2b_ready: valid/ready %b want 01", {out_valid, sample_ready});
    end
    to_issue(3'd5, 2);
    tests++;
    if ({core_x0, core_x1, core_y1} !== {32'sd2, 32'sd1, 32'sd11}) begin
      fails++; $display("FAIL b2b_ctx: x0 %0d x1 %0d y1 %0d want 2 1 11", core_x0, core_x1, core_y1);
    end
    finish_core(22);
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 3'd5, exp_y(22)}) begin
      fails++; $display("FAIL b2b_out: ch %0d data %0d want 5 %0d", out_ch, out_data, exp_y(22));
    end
    tick;
  endtask

`ifdef HPF_SETTLE_BLANK_EN
  task automatic test_settle;
    logic signed [31:0] want;
    for (int i = 1; i <= 257; i++) begin
      to_issue(3'd1, i);
      finish_core(1000 + i);
      want = i <= 256 ? 32'sd0 : 32'(1000 + i);
      tests++;
      if ({out_valid, out_data} !== {1'b1, want}) begin
        fails++; $display("FAIL settle_%0d: valid %b data %0d want 1 %0d", i, out_valid, out_data, want);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_main;
    test_context;
    test_timeout;
    test_bad_ch;
    test_enable;
    test_back_to_back;
`ifdef HPF_SETTLE_BLANK_EN
    test_settle;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
